// File: rtl/fifo_pkg.sv
// Shared widths and types for the 8x16 FIFO controller slice.
package fifo_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/fifo_ctrl_8x16_if.sv
// Push/pop stream and status bundle between a FIFO user (master) and the controller (slave).
interface fifo_ctrl_8x16_if;
  import fifo_pkg::*;

  logic  push;
  data_t push_data;
  logic  pop;
  logic  flush;
  logic  clear_err;
  data_t pop_data;
  logic  pop_valid;
  logic  full;
  logic  empty;
  logic  almost_full;
  cnt_t  count;
  logic  overflow;
  logic  underflow;

  modport master (
    output push, push_data, pop, flush, clear_err,
    input  pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop, flush, clear_err,
    output pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/dual_port_ram_8x16.sv
// 8x16 simple dual-port RAM: synchronous write, registered read with 1-cycle latency.
module dual_port_ram_8x16
  import fifo_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  ptr_t  wr_addr,
  input  data_t d_in,
  input  logic  re,
  input  ptr_t  rd_addr,
  output data_t d_out
);

  data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr] <= d_in;
    if (re)
      d_out <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_ptr_ctr.sv
// ADDR_W-bit wrapping pointer with synchronous clear (clear beats increment).
module fifo_ptr_ctr
  import fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output ptr_t ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (clr)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/fifo_ctrl_8x16.sv
// FIFO controller: turns push/pop requests into RAM addresses/enables and tracks occupancy.
module fifo_ctrl_8x16
  import fifo_pkg::*;
#(
  parameter int unsigned AF_THRESH = 6
)(
  input  logic             clk,
  input  logic             rst,
  fifo_ctrl_8x16_if.slave  bus,
  output logic             ram_we,
  output ptr_t             ram_wr_addr,
  output data_t            ram_d_in,
  output logic             ram_re,
  output ptr_t             ram_rd_addr,
  input  data_t            ram_d_out
);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count;
  logic full;
  logic empty;
  logic push_ok;
  logic pop_ok;
  logic pop_valid;
  logic overflow;
  logic underflow;

  // Status comes from the registered count only, so no bypass of a same-cycle push/pop.
  always_comb begin
    full    = (count == cnt_t'(DEPTH));
    empty   = (count == '0);
    push_ok = bus.push & ~full  & ~bus.flush;
    pop_ok  = bus.pop  & ~empty & ~bus.flush;
  end

  fifo_ptr_ctr u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .clr (bus.flush),
    .ptr (wr_ptr)
  );

  fifo_ptr_ctr u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .clr (bus.flush),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (bus.flush)
      count <= '0;
    else begin
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pop_valid <= 1'b0;
    else
      pop_valid <= pop_ok;
  end

  // Error flags are sticky across flush; a new error outranks clear_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.push & full)
        overflow <= 1'b1;
      else if (bus.clear_err)
        overflow <= 1'b0;
      if (bus.pop & empty)
        underflow <= 1'b1;
      else if (bus.clear_err)
        underflow <= 1'b0;
    end
  end

  always_comb begin
    ram_we      = push_ok;
    ram_wr_addr = wr_ptr;
    ram_d_in    = bus.push_data;
    ram_re      = pop_ok;
    ram_rd_addr = rd_ptr;
  end

  always_comb begin
    bus.pop_data    = ram_d_out;
    bus.pop_valid   = pop_valid;
    bus.full        = full;
    bus.empty       = empty;
    bus.almost_full = (count >= cnt_t'(AF_THRESH));
    bus.count       = count;
    bus.overflow    = overflow;
    bus.underflow   = underflow;
  end

endmodule
